// File: rtl/chimp_box_draw.sv
// Box rasteriser: draws one BOX_SIZE x BOX_SIZE grid cell, one pixel per clock, to a VGA adapter.
// Define CHIMP_BOX_BORDER_EN to plot only the perimeter (scan timing is unchanged).
module chimp_box_draw #(
  parameter int BOX_SIZE = 20,
  parameter int X_ORIGIN = 17,
  parameter int X_PITCH  = 37,
  parameter int Y_ORIGIN = 8,
  parameter int Y_PITCH  = 28
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [2:0] iBoxX,
  input  logic [2:0] iBoxY,
  input  logic [2:0] iColour,
  output logic [9:0] oX,
  output logic [8:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oBusy,
  output logic       oDone
);

  localparam int CW = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BOX_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      bx_q, bx_d, by_q, by_d, col_q, col_d;
  logic [9:0]      orgx_q, orgx_d;
  logic [8:0]      orgy_q, orgy_d;
  logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [2:0]      pcol_q, pcol_d;
  logic            plot_q, plot_d, done_q, done_d;
  logic            last_px, on_edge;

  assign last_px = (cx_q == LAST) && (cy_q == LAST);

  always_ff @(posedge clk) begin
    if (iReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_LOAD;
      S_LOAD:  state_d = S_DRAW;
      S_DRAW:  if (last_px) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first pixel lands
  // the cycle after LOAD; the origin is taken from its _d while in LOAD.
  always_comb begin
    bx_d   = bx_q;
    by_d   = by_q;
    col_d  = col_q;
    orgx_d = orgx_q;
    orgy_d = orgy_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    if (state_q == S_IDLE && iStart) begin
      bx_d  = iBoxX;
      by_d  = iBoxY;
      col_d = iColour;
    end
    if (state_q == S_LOAD) begin
      orgx_d = 10'(X_ORIGIN) + 10'(X_PITCH) * 10'(bx_q);
      orgy_d = 9'(Y_ORIGIN) + 9'(Y_PITCH) * 9'(by_q);
    end
    if (state_q == S_DRAW) begin
      if (cx_q == LAST) begin
        cx_d = '0;
        cy_d = (cy_q == LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end

    on_edge = (cx_d == '0) || (cx_d == LAST) || (cy_d == '0) || (cy_d == LAST);
`ifdef CHIMP_BOX_BORDER_EN
    plot_d = (state_d == S_DRAW) && on_edge;
`else
    plot_d = (state_d == S_DRAW);
`endif
    done_d = (state_d == S_DONE);
    x_d    = plot_d ? orgx_d + 10'(cx_d) : x_q;
    y_d    = plot_d ? orgy_d + 9'(cy_d)  : y_q;
    pcol_d = plot_d ? col_q : pcol_q;
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      bx_q   <= '0;
      by_q   <= '0;
      col_q  <= '0;
      orgx_q <= '0;
      orgy_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      pcol_q <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bx_q   <= bx_d;
      by_q   <= by_d;
      col_q  <= col_d;
      orgx_q <= orgx_d;
      orgy_q <= orgy_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      x_q    <= x_d;
      y_q    <= y_d;
      pcol_q <= pcol_d;
      plot_q <= plot_d;
      done_q <= done_d;
    end
  end

  assign oX      = x_q;
  assign oY      = y_q;
  assign oColour = pcol_q;
  assign oPlot   = plot_q;
  assign oDone   = done_q;
  assign oBusy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_chimp_box_draw.sv
// Bench for chimp_box_draw: table of boxes, random boxes against a pixel-list model,
// plus hand sequences for start disturbance, mid-draw reset and held start.
module tb_chimp_box_draw;

  localparam int S = 20;
`ifdef CHIMP_BOX_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam int NPIX = BORDER ? 4 * S - 4 : S * S;

  logic       clk = 1'b0;
  logic       iReset, iStart;
  logic [2:0] iBoxX, iBoxY, iColour;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [2:0] oColour;
  logic       oPlot, oBusy, oDone;

  chimp_box_draw dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iBoxX(iBoxX), .iBoxY(iBoxY),
    .iColour(iColour), .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int c; int x; int y; } pix_t;
  typedef struct { int bx; int by; int col; int fx; int fy; int lx; int ly; } vec_t;

  // Model: every pixel of the box in raster order, with the cycle (after the
  // start edge) on which it must appear.
  function automatic void build_model(input int bx, input int by, output pix_t q[$]);
    q = {};
    for (int yy = 0; yy < S; yy++)
      for (int xx = 0; xx < S; xx++)
        if (!BORDER || xx == 0 || yy == 0 || xx == S - 1 || yy == S - 1)
          q.push_back('{c: 2 + yy * S + xx, x: 17 + 37 * bx + xx, y: 8 + 28 * by + yy});
  endfunction

  int r_plots, r_fx, r_fy, r_lx, r_ly, r_done_n, r_done_cyc;

  task automatic run_box(input int bx, input int by, input int col, input bit disturb,
                         input string tag);
    pix_t q[$];
    int idx, pix_err, col_err, busy_err;
    build_model(bx, by, q);
    @(negedge clk);
    iBoxX = 3'(bx); iBoxY = 3'(by); iColour = 3'(col); iStart = 1'b1;
    @(posedge clk);
    idx = 0; pix_err = 0; col_err = 0; busy_err = 0;
    r_plots = 0; r_done_n = 0; r_done_cyc = -1;
    r_fx = -1; r_fy = -1; r_lx = -1; r_ly = -1;
    for (int c = 1; c <= 410; c++) begin
      @(negedge clk);
      if (oBusy != (c <= 402)) busy_err++;
      if (oDone) begin r_done_n++; r_done_cyc = c; end
      if (oPlot) begin
        r_plots++;
        if (r_fx < 0) begin r_fx = int'(oX); r_fy = int'(oY); end
        r_lx = int'(oX); r_ly = int'(oY);
        if (oColour != 3'(col)) col_err++;
        if (idx < q.size() && q[idx].c == c && q[idx].x == int'(oX) && q[idx].y == int'(oY)) idx++;
        else pix_err++;
      end else if (idx < q.size() && q[idx].c == c) begin
        pix_err++;
        idx++;
      end
      if (disturb && c < 403) begin
        iStart = 1'($urandom); iBoxX = 3'($urandom); iBoxY = 3'($urandom); iColour = 3'($urandom);
      end else begin
        iStart = 1'b0;
      end
    end
    if (idx != q.size()) pix_err++;
    check({tag, "_pixels"}, pix_err, 0);
    check({tag, "_colour"}, col_err, 0);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_nplots"}, r_plots, NPIX);
    check({tag, "_ndone"}, r_done_n, 1);
    check({tag, "_donecyc"}, r_done_cyc, 402);
    check({tag, "_firstx"}, r_fx, q[0].x);
    check({tag, "_lasty"}, r_ly, q[q.size() - 1].y);
  endtask

  vec_t tbl[4];

  initial begin
    int fired, rc, post_done, post_plot, target, dn, dc1, dc2, pl, bl, fp2;
    tbl[0] = '{bx: 0, by: 0, col: 4, fx: 17,  fy: 8,   lx: 36,  ly: 27};
    tbl[1] = '{bx: 7, by: 7, col: 5, fx: 276, fy: 204, lx: 295, ly: 223};
    tbl[2] = '{bx: 3, by: 5, col: 2, fx: 128, fy: 148, lx: 147, ly: 167};
    tbl[3] = '{bx: 6, by: 1, col: 7, fx: 239, fy: 36,  lx: 258, ly: 55};

    iReset = 1'b1; iStart = 1'b1; iBoxX = 3'd5; iBoxY = 3'd5; iColour = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", int'(oX), 0);
    check("rst_y", int'(oY), 0);
    check("rst_colour", int'(oColour), 0);
    check("rst_plot", int'(oPlot), 0);
    check("rst_busy", int'(oBusy), 0);
    check("rst_done", int'(oDone), 0);
    iReset = 1'b0; iStart = 1'b0;

    foreach (tbl[i]) begin
      run_box(tbl[i].bx, tbl[i].by, tbl[i].col, 1'b0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_fx", i), r_fx, tbl[i].fx);
      check($sformatf("tbl%0d_fy", i), r_fy, tbl[i].fy);
      check($sformatf("tbl%0d_lx", i), r_lx, tbl[i].lx);
      check($sformatf("tbl%0d_ly", i), r_ly, tbl[i].ly);
    end

    for (int i = 0; i < 4; i++)
      run_box(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'b0, $sformatf("rnd%0d", i));

    // Start pulses and input churn during LOAD/DRAW/DONE must be ignored.
    run_box(4, 2, 1, 1'b1, "disturb");

    // Reset at a mid-draw plot aborts with no done pulse.
    target = BORDER ? 40 : 100;
    @(negedge clk);
    iBoxX = 3'd2; iBoxY = 3'd3; iColour = 3'd6; iStart = 1'b1;
    @(posedge clk);
    fired = 0; rc = 0; pl = 0; post_done = 0; post_plot = 0;
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      iStart = 1'b0;
      if (fired == 0) begin
        if (oPlot) pl++;
        if (oDone) post_done++;
        if (pl == target) begin iReset = 1'b1; fired = 1; rc = c; end
      end else begin
        if (c == rc + 1) begin
          check("rstmid_plot", int'(oPlot), 0);
          check("rstmid_busy", int'(oBusy), 0);
          check("rstmid_done", int'(oDone), 0);
          check("rstmid_x", int'(oX), 0);
          iReset = 1'b0;
        end else begin
          if (oDone) post_done++;
          if (oPlot) post_plot++;
        end
        if (c >= rc + 410) break;
      end
    end
    check("rstmid_fired", fired, 1);
    check("rstmid_nodone", post_done, 0);
    check("rstmid_noplot", post_plot, 0);
    iReset = 1'b0;
    run_box(2, 3, 6, 1'b0, "after_rst");

    // Held start: boxes back to back, 403-cycle period.
    @(negedge clk);
    iBoxX = 3'd1; iBoxY = 3'd2; iColour = 3'd3; iStart = 1'b1;
    @(posedge clk);
    dn = 0; dc1 = -1; dc2 = -1; pl = 0; bl = 0; fp2 = -1;
    for (int c = 1; c <= 806; c++) begin
      @(negedge clk);
      if (oDone) begin dn++; if (dc1 < 0) dc1 = c; else dc2 = c; end
      if (oPlot) begin pl++; if (c > 403 && fp2 < 0) fp2 = c; end
      if (!oBusy) bl++;
    end
    iStart = 1'b0;
    check("hold_ndone", dn, 2);
    check("hold_done1", dc1, 402);
    check("hold_done2", dc2, 805);
    check("hold_plots", pl, 2 * NPIX);
    check("hold_idle_cycles", bl, 2);
    check("hold_first2", fp2, 405);
    repeat (3) @(negedge clk);
    check("hold_release_busy", int'(oBusy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chimp_box_draw.md
CHIMP_BOX_DRAW -- requirements
Module: chimp_box_draw

Interface
REQ-001 The module SHALL have parameter BOX_SIZE, default 20, giving the box edge length in pixels.
REQ-002 The module SHALL have parameter X_ORIGIN, default 17, giving the left pixel of grid column 0.
REQ-003 The module SHALL have parameter X_PITCH, default 37, giving the pixel distance between adjacent grid columns.
REQ-004 The module SHALL have parameter Y_ORIGIN, default 8, giving the top pixel of grid row 0.
REQ-005 The module SHALL have parameter Y_PITCH, default 28, giving the pixel distance between adjacent grid rows.
REQ-006 The module SHALL have a single clock, clk  input  1, and all logic SHALL be clocked on its rising edge.
REQ-007 The module SHALL have iReset  input  1, a synchronous, active-high reset.
REQ-008 The module SHALL have iStart  input  1, a request to draw one box.
REQ-009 The module SHALL have iBoxX  input  3, the grid column 0..7.
REQ-010 The module SHALL have iBoxY  input  3, the grid row 0..7.
REQ-011 The module SHALL have iColour  input  3, the fill colour.
REQ-012 The module SHALL have oX  output  10, the pixel x coordinate.
REQ-013 The module SHALL have oY  output  9, the pixel y coordinate.
REQ-014 The module SHALL have oColour  output  3, the pixel colour.
REQ-015 The module SHALL have oPlot  output  1, a write strobe to the VGA adapter.
REQ-016 The module SHALL have oBusy  output  1, high in every state except IDLE.
REQ-017 The module SHALL have oDone  output  1, a one-cycle completion pulse.

Function
REQ-018 The block SHALL be the inverse of the click-to-grid mapping: box (bx,by) SHALL occupy x = X_ORIGIN+X_PITCH*bx .. +BOX_SIZE-1 and y = Y_ORIGIN+Y_PITCH*by .. +BOX_SIZE-1.
- With default parameters, box (bx,by) SHALL occupy x 17+37*bx..36+37*bx and y 8+28*by..27+28*by.
REQ-019 The FSM SHALL have four states with these transitions:
- IDLE -> LOAD when iStart=1.
- LOAD -> DRAW unconditionally.
- DRAW -> DONE after the last pixel.
- DONE -> IDLE unconditionally.
REQ-020 In IDLE, iStart=1 SHALL latch iBoxX, iBoxY and iColour.
- iStart SHALL be ignored in LOAD, DRAW and DONE, with no queuing.
REQ-021 LOAD SHALL compute the registered box origin: the multiply by a constant pitch, 10-bit x and 9-bit y, with no overflow for any 3-bit index at default parameters.
REQ-022 DRAW SHALL scan BOX_SIZE*BOX_SIZE pixels in row-major order, one per clock.
- x SHALL be the inner counter and y the outer counter.
- Counter wrap SHALL be at BOX_SIZE-1, with the x counter resetting to 0 and y incrementing.
REQ-023 oX, oY, oColour and oPlot SHALL be registered.
- oPlot SHALL be 1 exactly on cycles presenting a pixel to be written.
- oPlot SHALL be 0 in IDLE, LOAD and DONE.
REQ-024 Cycle timing SHALL be as follows, for iStart sampled at edge k:
- LOAD at k+1.
- Pixels on cycles k+2..k+401 (default size).
- oDone=1 for the single cycle k+402.
- Back in IDLE at k+403.
REQ-025 oX, oY and oColour SHALL hold their last values when oPlot=0.
REQ-026 Latched inputs SHALL be unaffected by changes to iBoxX, iBoxY or iColour during a draw.

Reset
REQ-027 iReset=1 at a rising edge SHALL force IDLE and clear the counters, with oX=0, oY=0, oColour=0, oPlot=0, oBusy=0 and oDone=0 after that edge.
REQ-028 Reset mid-DRAW SHALL abort the draw with no oDone pulse.
REQ-029 Reset SHALL take priority over a simultaneous iStart.

Configuration
REQ-030 The macro CHIMP_BOX_BORDER_EN SHALL select the plotting mode.
- When defined, oPlot SHALL be asserted only for perimeter pixels, where the x or y counter is 0 or BOX_SIZE-1: 76 plots for size 20.
- With CHIMP_BOX_BORDER_EN defined, the DRAW duration, scan order and oDone timing SHALL be unchanged.
- When undefined, every pixel SHALL be plotted: 400 plots.

Verification
REQ-031 The bench SHALL drive iStart, box (0,0), colour 3'b100 -> first plot (17,8), last plot (36,27), 400 plots, oDone 402 cycles after the start edge.
REQ-032 The bench SHALL drive box (7,7) -> first plot (276,204), last plot (295,223), with all oColour values equal to the latched colour.
REQ-033 The bench SHALL drive iStart pulses and changing iBoxX/iBoxY during DRAW and DONE -> no restart, coordinates from the original box only, a single oDone.
REQ-034 The bench SHALL assert iReset at the 100th plot -> next cycle oPlot=0, oBusy=0, no oDone; a new iStart then draws the full box.
REQ-035 The bench SHALL repeat REQ-031 with CHIMP_BOX_BORDER_EN defined -> 76 plots, none with x in 18..35 and y in 9..26, oDone timing identical.
REQ-036 The bench SHALL drive iStart held high continuously -> boxes drawn back-to-back with a 403-cycle period and one oDone per box.
